// File: rtl/captura_tabla_verdad.sv
// captura_tabla_verdad
//   Captures (input vector, response) pairs from a combinational DUT into a
//   2^N_IN-entry truth table. It tracks coverage, flags vectors that come back
//   with a different response, and provides a registered read port.
//
// Ports
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   start             pulse: clear coverage/flags and enter CAPTURE
//   in_valid/in_vec/in_resp/in_ready  capture handshake
//   rd_en/rd_addr     read request; rd_data/rd_valid answer one cycle later
//   covered           count of distinct vectors captured (0..2^N_IN)
//   complete          every vector captured (DONE state)
//   conflict          sticky: a vector was seen again with a different response
module captura_tabla_verdad #(
  parameter int unsigned N_IN  = 6,
  parameter int unsigned N_OUT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [N_IN-1:0]   in_vec,
  input  logic [N_OUT-1:0]  in_resp,
  output logic              in_ready,
  input  logic              rd_en,
  input  logic [N_IN-1:0]   rd_addr,
  output logic [N_OUT-1:0]  rd_data,
  output logic              rd_valid,
  output logic [N_IN:0]     covered,
  output logic              complete,
  output logic              conflict
);

  localparam int unsigned DEPTH = 2 ** N_IN;
  localparam logic [N_IN:0] LAST_COUNT = (N_IN + 1)'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t state, state_nx;

  logic [N_OUT-1:0] tbl [DEPTH];
  logic [DEPTH-1:0] seen;

  logic accept;
  logic new_entry;
  logic mismatch;

  // start takes priority: a pair presented in the same cycle is dropped.
  assign accept    = in_valid && in_ready && !start;
  assign new_entry = accept && !seen[in_vec];
  assign mismatch  = accept && seen[in_vec] && (tbl[in_vec] != in_resp);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    in_ready = 1'b0;
    complete = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_nx = CAPTURE;
      end
      CAPTURE: begin
        in_ready = 1'b1;
        if (start)
          state_nx = CAPTURE;
        else if (new_entry && covered == LAST_COUNT)
          state_nx = DONE;
      end
      DONE: begin
        complete = 1'b1;
        if (start) state_nx = CAPTURE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seen     <= '0;
      covered  <= '0;
      conflict <= 1'b0;
    end else if (start) begin
      seen     <= '0;
      covered  <= '0;
      conflict <= 1'b0;
    end else begin
      if (new_entry) begin
        seen[in_vec] <= 1'b1;
        covered      <= covered + 1'b1;
      end
      if (mismatch) conflict <= 1'b1;
    end
  end

  // Table contents are not reset; the seen bitmap gates every read.
  always_ff @(posedge clk) begin
    if (new_entry) tbl[in_vec] <= in_resp;
  end

  // The read samples the pre-edge table and seen bits, which gives
  // read-before-write on a same-address collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en && seen[rd_addr];
      rd_data  <= (rd_en && seen[rd_addr]) ? tbl[rd_addr] : '0;
    end
  end

endmodule

// File: tb/tb_captura_tabla_verdad.sv
module tb_captura_tabla_verdad;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       in_valid;
  logic [5:0] in_vec;
  logic [1:0] in_resp;
  logic       in_ready;
  logic       rd_en;
  logic [5:0] rd_addr;
  logic [1:0] rd_data;
  logic       rd_valid;
  logic [6:0] covered;
  logic       complete;
  logic       conflict;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [5:0] vec;
    logic [1:0] resp;
    int         exp_cov;
    logic       exp_ready;
    logic       exp_complete;
  } vec_t;

  vec_t sweep [64];

  captura_tabla_verdad #(.N_IN(6), .N_OUT(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .in_valid (in_valid),
    .in_vec   (in_vec),
    .in_resp  (in_resp),
    .in_ready (in_ready),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .covered  (covered),
    .complete (complete),
    .conflict (conflict)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_read(input logic [5:0] a, input logic [1:0] exp_d,
                         input logic exp_v, input string name);
    rd_en   = 1'b1;
    rd_addr = a;
    step();
    rd_en   = 1'b0;
    chk({name, " rd_valid"}, int'(rd_valid), int'(exp_v));
    chk({name, " rd_data"},  int'(rd_data),  int'(exp_d));
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      logic [5:0] v;
      v = 6'(i);
      sweep[i].vec          = v;
      sweep[i].resp         = v[1:0] ^ v[5:4];
      sweep[i].exp_cov      = i + 1;
      sweep[i].exp_ready    = (i != 63);
      sweep[i].exp_complete = (i == 63);
    end

    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_vec = '0; in_resp = '0;
    rd_en = 1'b0; rd_addr = '0;
    #2;
    chk("rst in_ready", int'(in_ready), 0);
    chk("rst covered",  int'(covered),  0);
    chk("rst complete", int'(complete), 0);
    chk("rst conflict", int'(conflict), 0);
    chk("rst rd_valid", int'(rd_valid), 0);
    chk("rst rd_data",  int'(rd_data),  0);
    #10 rst_n = 1'b1;
    step();

    // Idle: input without start is not accepted.
    in_valid = 1'b1; in_vec = 6'h05; in_resp = 2'b10;
    chk("idle in_ready", int'(in_ready), 0);
    step();
    in_valid = 1'b0;
    chk("idle covered", int'(covered), 0);
    do_read(6'h05, 2'b00, 1'b0, "idle read5");

    // Exhaustive sweep from the vector table.
    start = 1'b1; step(); start = 1'b0;
    chk("sweep in_ready", int'(in_ready), 1);
    for (int i = 0; i < 64; i++) begin
      in_valid = 1'b1; in_vec = sweep[i].vec; in_resp = sweep[i].resp;
      step();
      chk($sformatf("sweep cov[%0d]", i), int'(covered), sweep[i].exp_cov);
      chk($sformatf("sweep ready[%0d]", i), int'(in_ready), int'(sweep[i].exp_ready));
      chk($sformatf("sweep cmpl[%0d]", i), int'(complete), int'(sweep[i].exp_complete));
    end
    in_valid = 1'b0;
    chk("sweep conflict", int'(conflict), 0);
    do_read(6'h3A, 2'b01, 1'b1, "sweep read3A");
    for (int i = 0; i < 64; i++)
      do_read(sweep[i].vec, sweep[i].resp, 1'b1, $sformatf("readback[%0d]", i));

    // DONE ignores input.
    in_valid = 1'b1; in_vec = 6'h00; in_resp = 2'b11;
    step();
    in_valid = 1'b0;
    chk("done covered",  int'(covered),  64);
    chk("done conflict", int'(conflict), 0);
    chk("done complete", int'(complete), 1);
    do_read(6'h00, 2'b00, 1'b1, "done read0");

    // Duplicate and conflict.
    start = 1'b1; step(); start = 1'b0;
    chk("restart complete", int'(complete), 0);
    chk("restart covered",  int'(covered),  0);
    in_valid = 1'b1; in_vec = 6'd7; in_resp = 2'b01; step();
    chk("dup1 covered", int'(covered), 1);
    step();
    chk("dup2 covered",  int'(covered),  1);
    chk("dup2 conflict", int'(conflict), 0);
    in_resp = 2'b11; step();
    in_valid = 1'b0;
    chk("dup3 covered",  int'(covered),  1);
    chk("dup3 conflict", int'(conflict), 1);
    do_read(6'd7, 2'b01, 1'b1, "dup read7");

    // Read/write collision returns the old (unwritten) contents.
    in_valid = 1'b1; in_vec = 6'd9; in_resp = 2'b10;
    rd_en = 1'b1; rd_addr = 6'd9;
    step();
    in_valid = 1'b0; rd_en = 1'b0;
    chk("coll rd_valid", int'(rd_valid), 0);
    chk("coll rd_data",  int'(rd_data),  0);
    chk("coll covered",  int'(covered),  2);
    do_read(6'd9, 2'b10, 1'b1, "coll read9");

    // 30 more captures, then restart clears coverage and the sticky conflict.
    for (int i = 10; i < 40; i++) begin
      in_valid = 1'b1; in_vec = 6'(i); in_resp = 2'(i); step();
    end
    in_valid = 1'b0;
    chk("pre-restart covered",  int'(covered),  32);
    chk("pre-restart conflict", int'(conflict), 1);
    start = 1'b1; in_valid = 1'b1; in_vec = 6'd50; in_resp = 2'b01;
    step();
    start = 1'b0; in_valid = 1'b0;
    chk("restart2 covered",  int'(covered),  0);
    chk("restart2 conflict", int'(conflict), 0);
    chk("restart2 in_ready", int'(in_ready), 1);
    do_read(6'd9, 2'b00, 1'b0, "restart2 read9");

    // 10 captures with a read of entry 0 in flight, then async reset.
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_vec = 6'(i); in_resp = 2'b11;
      rd_en = (i >= 5); rd_addr = 6'd0;
      step();
    end
    in_valid = 1'b0; rd_en = 1'b0;
    chk("mid covered",  int'(covered),  10);
    chk("mid rd_valid", int'(rd_valid), 1);
    chk("mid rd_data",  int'(rd_data),  3);
    #2 rst_n = 1'b0;
    #1;
    chk("async in_ready", int'(in_ready), 0);
    chk("async covered",  int'(covered),  0);
    chk("async complete", int'(complete), 0);
    chk("async conflict", int'(conflict), 0);
    chk("async rd_valid", int'(rd_valid), 0);
    chk("async rd_data",  int'(rd_data),  0);
    #10 rst_n = 1'b1;
    in_valid = 1'b1; in_vec = 6'd3; in_resp = 2'b01;
    step();
    in_valid = 1'b0;
    chk("post-rst idle covered", int'(covered), 0);
    do_read(6'd0, 2'b00, 1'b0, "post-rst read0");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
